alu_operand_issue: RTL

- Producer side of the ALU operand interface: converts decoded instruction fields into the `src1`/`src2`/`aluOp` triple consumed by the ALU sub-units.
- Does immediate extension and shift-amount masking.
- Registers the result behind a 2-entry skid buffer with valid/ready handshakes on both sides.
- Sits between decode and the ALU execute stage, and supports pipeline flush.

---
 rtl/alu_operand_issue_if.sv | 33 +++
 rtl/alu_operand_issue.sv | 80 ++++++++
 2 files changed

// File: rtl/alu_operand_issue_if.sv
// alu_operand_issue_if: decode-side and ALU-side handshake bundle for the operand issue stage
interface alu_operand_issue_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int DEST_W = 5,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_class;
  logic [3:0]        in_funct;
  logic [DATA_W-1:0] in_rs_val;
  logic [DATA_W-1:0] in_rt_val;
  logic [IMM_W-1:0]  in_imm;
  logic [DEST_W-1:0] in_dest;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [3:0]        aluOp;
  logic [DEST_W-1:0] out_dest;
  logic              illegal_pulse;
  logic [CNT_W-1:0]  issue_count;
  modport master (
    input  flush, in_valid, in_class, in_funct, in_rs_val, in_rt_val, in_imm, in_dest, out_ready,
    output in_ready, out_valid, src1, src2, aluOp, out_dest, illegal_pulse, issue_count
  );
  modport slave (
    output flush, in_valid, in_class, in_funct, in_rs_val, in_rt_val, in_imm, in_dest, out_ready,
    input  in_ready, out_valid, src1, src2, aluOp, out_dest, illegal_pulse, issue_count
  );
endinterface

// File: rtl/alu_operand_issue.sv
// alu_operand_issue: formats decoded fields into ALU operands behind a 2-entry skid buffer
module alu_operand_issue #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int DEST_W = 5,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  alu_operand_issue_if.master io
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
    logic [3:0]        op;
    logic [DEST_W-1:0] dest;
  } entry_t;
  state_t            state, state_n;
  entry_t            main_q, skid_q, main_n, skid_n, fmt;
  logic              is_shift, bad, acc, iss, push, ill_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] sh_rt, sh_imm, sext, zext;
  always_comb begin
    is_shift = io.in_funct >= 4'hd;
    sh_rt    = DATA_W'(io.in_rt_val[4:0]);
    sh_imm   = DATA_W'(io.in_imm[4:0]);
    sext     = {{(DATA_W-IMM_W){io.in_imm[IMM_W-1]}}, io.in_imm};
    zext     = DATA_W'(io.in_imm);
    bad      = io.in_class == 2'b11 || (io.in_class == 2'b10 && !is_shift);
    fmt.s1   = io.in_rs_val;
    fmt.op   = io.in_funct;
    fmt.dest = io.in_dest;
    fmt.s2   = io.in_funct == 4'hc ? '0 :
               is_shift ? (io.in_class == 2'b00 ? sh_rt : sh_imm) :
               io.in_class == 2'b00 ? io.in_rt_val :
               io.in_funct[3] ? zext : sext;
    acc      = io.in_valid & io.in_ready;
    iss      = io.out_valid & io.out_ready;
    push     = acc & !bad;
    state_n  = state;
    main_n   = main_q;
    skid_n   = skid_q;
    case (state)
      EMPTY: if (push) begin state_n = ONE; main_n = fmt; end
      ONE: begin
        if (push && iss) main_n = fmt;
        else if (push) begin state_n = FULL; skid_n = fmt; end
        else if (iss) state_n = EMPTY;
      end
      FULL: if (iss) begin state_n = ONE; main_n = skid_q; end
      default: state_n = EMPTY;
    endcase
    if (io.flush) state_n = EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      ill_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
      ill_q  <= acc & bad & !io.flush;
      cnt_q  <= cnt_q + CNT_W'(iss);
    end
  end
  // ready comes straight from the state register, never from out_ready
  assign io.in_ready      = state != FULL;
  assign io.out_valid     = state != EMPTY;
  assign io.src1          = main_q.s1;
  assign io.src2          = main_q.s2;
  assign io.aluOp         = main_q.op;
  assign io.out_dest      = main_q.dest;
  assign io.illegal_pulse = ill_q;
  assign io.issue_count   = cnt_q;
endmodule
